// File: rtl/button_debouncer_if.sv
// Signal bundle between a debouncer and its consumer: synchronized level in, clean level,
// edge pulses, hold flag and auto-repeat pulse out.
interface button_debouncer_if;
    logic value_i;
    logic value_o;
    logic pressed_o;
    logic released_o;
    logic held_o;
    logic repeat_o;

    modport master (
        output value_i,
        input  value_o,
        input  pressed_o,
        input  released_o,
        input  held_o,
        input  repeat_o
    );

    modport slave (
        input  value_i,
        output value_o,
        output pressed_o,
        output released_o,
        output held_o,
        output repeat_o
    );
endinterface

// File: rtl/button_debouncer.sv
// Debouncer for one synchronized button level: clean level, press/release pulses, long-hold flag.
// Auto-repeat pulses exist only when BUTTON_DEBOUNCER_AUTOREPEAT_EN is defined.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 100000000,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input logic               clock_i,
    input logic               reset_i,
    button_debouncer_if.slave bus_io
);

    localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DebW-1:0]  DebOne   = DebW'(1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        StLow,
        StConfirmHigh,
        StHigh,
        StConfirmLow
    } state_e;

    state_e            state_q;
    logic [DebW-1:0]   deb_cnt_q;
    logic [HoldW-1:0]  hold_cnt_q;
    logic              value_q;
    logic              pressed_q;
    logic              released_q;
    logic              held_q;

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    localparam int unsigned RptW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RptW-1:0] RptLast = RptW'(REPEAT_CYCLES - 1);

    logic [RptW-1:0] rpt_cnt_q;
    logic            repeat_q;
`endif

    logic hold_active;
    logic release_now;

    assign hold_active = (state_q == StHigh) || (state_q == StConfirmLow);
    assign release_now = (state_q == StConfirmLow) && !bus_io.value_i && (deb_cnt_q == DebLast);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StLow;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            value_q    <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            held_q     <= 1'b0;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
            rpt_cnt_q  <= '0;
            repeat_q   <= 1'b0;
`endif
        end else begin
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
            repeat_q   <= 1'b0;
`endif
            unique case (state_q)
                StLow: begin
                    if (bus_io.value_i) begin
                        state_q   <= StConfirmHigh;
                        deb_cnt_q <= DebOne;
                    end
                end
                StConfirmHigh: begin
                    if (!bus_io.value_i) begin
                        state_q   <= StLow;
                        deb_cnt_q <= '0;
                    end else if (deb_cnt_q == DebLast) begin
                        state_q   <= StHigh;
                        deb_cnt_q <= '0;
                        value_q   <= 1'b1;
                        pressed_q <= 1'b1;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + 1'b1;
                    end
                end
                StHigh: begin
                    if (!bus_io.value_i) begin
                        state_q   <= StConfirmLow;
                        deb_cnt_q <= DebOne;
                    end
                end
                StConfirmLow: begin
                    if (bus_io.value_i) begin
                        state_q   <= StHigh;
                        deb_cnt_q <= '0;
                    end else if (release_now) begin
                        state_q    <= StLow;
                        deb_cnt_q  <= '0;
                        value_q    <= 1'b0;
                        released_q <= 1'b1;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= StLow;
                    deb_cnt_q <= '0;
                end
            endcase

            // Hold tracking spans HIGH and CONFIRM_LOW so short release bounces do not restart it.
            if (release_now) begin
                hold_cnt_q <= '0;
                held_q     <= 1'b0;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
                rpt_cnt_q  <= '0;
`endif
            end else if (hold_active) begin
                if (hold_cnt_q != HoldMax) begin
                    hold_cnt_q <= hold_cnt_q + 1'b1;
                end
                if (hold_cnt_q == HoldLast) begin
                    held_q    <= 1'b1;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
                    repeat_q  <= 1'b1;
                    rpt_cnt_q <= '0;
`endif
                end
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
                else if (held_q) begin
                    if (rpt_cnt_q == RptLast) begin
                        repeat_q  <= 1'b1;
                        rpt_cnt_q <= '0;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q + 1'b1;
                    end
                end
`endif
            end
        end
    end

    assign bus_io.value_o    = value_q;
    assign bus_io.pressed_o  = pressed_q;
    assign bus_io.released_o = released_q;
    assign bus_io.held_o     = held_q;

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    assign bus_io.repeat_o = repeat_q;
`else
    // Repeat period is meaningless without auto-repeat; keep the parameter referenced.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^REPEAT_CYCLES;
    assign bus_io.repeat_o   = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer (DEBOUNCE=4, HOLD=10, REPEAT=3): vector table plus reset sequence.
// Expected repeat_o follows whether BUTTON_DEBOUNCER_AUTOREPEAT_EN is defined.
module tb_button_debouncer;

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    localparam bit RptOn = 1'b1;
`else
    localparam bit RptOn = 1'b0;
`endif

    // Expected output word: {value, pressed, released, held, repeat}
    typedef struct {
        logic       v;
        logic [4:0] exp;
        string      name;
    } vec_t;

    typedef struct {
        logic [4:0] exp;
        string      name;
    } sb_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    button_debouncer_if bus_if ();

    button_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10),
        .REPEAT_CYCLES  (3)
    ) dut (
        .clock_i(clock),
        .reset_i(reset),
        .bus_io (bus_if)
    );

    always #5 clock = ~clock;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [4:0] outs();
        return {bus_if.value_o, bus_if.pressed_o, bus_if.released_o, bus_if.held_o,
                bus_if.repeat_o};
    endfunction

    function automatic void add(input logic v, input logic [4:0] exp, input string name);
        vec_t r;
        r.v    = v;
        r.exp  = {exp[4:1], exp[0] & RptOn};
        r.name = name;
        vecs.push_back(r);
    endfunction

    function automatic void add_n(input int n, input logic v, input logic [4:0] exp,
                                  input string name);
        for (int i = 0; i < n; i++) add(v, exp, name);
    endfunction

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (value,pressed,released,held,repeat)",
                     name, got, exp);
        end
    endtask

    // Drive one sample, queue its expectation, compare just after the edge.
    task automatic apply(input logic v, input logic [4:0] exp, input string name);
        sb_t e;
        bus_if.value_i = v;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check(e.name, outs(), e.exp);
    endtask

    initial begin
        bus_if.value_i = 1'b0;

        // Glitch of 3 highs rejected, then a clean 4-sample press.
        add_n(3, 1'b1, 5'b00000, "glitch_high");
        add  (   1'b0, 5'b00000, "glitch_drop");
        add_n(3, 1'b1, 5'b00000, "press_confirm");
        add  (   1'b1, 5'b11000, "press_edge");
        add  (   1'b1, 5'b10000, "press_pulse_end");
        // Release bounce 0,0,1 then four 0s.
        add_n(2, 1'b0, 5'b10000, "rel_bounce_low");
        add  (   1'b1, 5'b10000, "rel_bounce_high");
        add_n(3, 1'b0, 5'b10000, "rel_confirm");
        add  (   1'b0, 5'b00100, "release_edge");
        add  (   1'b0, 5'b00000, "release_pulse_end");
        // Press, hold with low bounces; held at k=10, repeat at 10,13,16,19,22.
        add_n(3, 1'b1, 5'b00000, "hold_press_confirm");
        add  (   1'b1, 5'b11000, "hold_press_edge");
        add_n(3, 1'b1, 5'b10000, "hold_k1_3");
        add_n(2, 1'b0, 5'b10000, "hold_bounce_k4_5");
        add_n(4, 1'b1, 5'b10000, "hold_k6_9");
        add  (   1'b1, 5'b10011, "held_rise_k10");
        add_n(2, 1'b1, 5'b10010, "held_k11_12");
        add  (   1'b1, 5'b10011, "repeat_k13");
        add_n(2, 1'b0, 5'b10010, "held_bounce_k14_15");
        add  (   1'b1, 5'b10011, "repeat_k16");
        add_n(2, 1'b1, 5'b10010, "held_k17_18");
        add  (   1'b1, 5'b10011, "repeat_k19");
        add  (   1'b1, 5'b10010, "held_k20");
        add  (   1'b0, 5'b10010, "rel_k21");
        add  (   1'b0, 5'b10011, "repeat_k22_confirm_low");
        add  (   1'b0, 5'b10010, "rel_k23");
        add  (   1'b0, 5'b00100, "held_release_k24");
        add_n(4, 1'b0, 5'b00000, "after_release");

        #12;
        check("reset_state", outs(), 5'b00000);
        #1 reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i].v, vecs[i].exp, vecs[i].name);

        // Asynchronous reset mid-cycle while pressed with value_i still high.
        apply(1'b1, 5'b00000, "rst_seq_confirm");
        apply(1'b1, 5'b00000, "rst_seq_confirm");
        apply(1'b1, 5'b00000, "rst_seq_confirm");
        apply(1'b1, 5'b11000, "rst_seq_press_edge");
        apply(1'b1, 5'b10000, "rst_seq_high");
        #3 reset = 1'b1;
        #1 check("reset_async_immediate", outs(), 5'b00000);
        @(posedge clock);
        #1 check("reset_held_over_edge", outs(), 5'b00000);
        #2 reset = 1'b0;
        apply(1'b1, 5'b00000, "post_reset_confirm1");
        apply(1'b1, 5'b00000, "post_reset_confirm2");
        apply(1'b1, 5'b00000, "post_reset_confirm3");
        apply(1'b1, 5'b11000, "post_reset_press_edge");
        apply(1'b1, 5'b10000, "post_reset_high");
        apply(1'b0, 5'b10000, "post_reset_rel1");
        apply(1'b0, 5'b10000, "post_reset_rel2");
        apply(1'b0, 5'b10000, "post_reset_rel3");
        apply(1'b0, 5'b00100, "post_reset_release_edge");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
